// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared types and constants for the RV core pipeline registers
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Stage payloads carried across the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_reg_d;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } id_reg_d;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
  } ex_reg_d;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_reg_d;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    if (main_v && skid_v) return OCC_FULL;
    if (main_v || skid_v) return OCC_ONE;
    return OCC_EMPTY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// pipe_skid_buf : one skid slot plus registered in_ready for pipe_stage_reg
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] in_data,
  output logic             skid_valid,
  output logic [WIDTH-1:0] skid_data,
  output logic             in_ready
);

  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;

  // r_ready mirrors !r_valid but is its own flop so upstream sees no logic depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else if (load) begin
      r_valid <= 1'b1;
      r_ready <= 1'b0;
    end else if (drain) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && load) r_data <= in_data;
  end

  assign skid_valid = r_valid;
  assign skid_data  = r_data;
  assign in_ready   = r_ready;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : generic valid/ready pipeline stage register with flush;
//                  optional skid slot enabled by macro PIPE_SKID_EN
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } pipe_slot_t;

  pipe_slot_t       r_main;
  logic             w_main_free;
  logic             w_accept;
  logic             w_skid_valid;
  logic             w_skid_drain;
  logic [WIDTH-1:0] w_skid_data;

  // Main slot can take a new entry at this edge if empty or being consumed.
  assign w_main_free  = !r_main.valid | out_ready;
  assign w_accept     = in_valid & in_ready;
  assign w_skid_drain = w_skid_valid & w_main_free;

`ifdef PIPE_SKID_EN
  logic w_skid_load;
  assign w_skid_load = w_accept & !w_main_free;

  pipe_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .load      (w_skid_load),
    .drain     (w_skid_drain),
    .in_data   (in_data),
    .skid_valid(w_skid_valid),
    .skid_data (w_skid_data),
    .in_ready  (in_ready)
  );
`else
  assign w_skid_valid = 1'b0;
  assign w_skid_data  = '0;
  assign in_ready     = w_main_free;
`endif

  // Skid entry wins over a fresh accept so ordering is kept (in_ready is low then anyway).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main.valid <= 1'b0;
      r_main.data  <= RST_VAL;
    end else if (flush) begin
      r_main.valid <= 1'b0;
    end else if (w_skid_drain) begin
      r_main.valid <= 1'b1;
      r_main.data  <= w_skid_data;
    end else if (w_accept && w_main_free) begin
      r_main.valid <= 1'b1;
      r_main.data  <= in_data;
    end else if (out_ready) begin
      r_main.valid <= 1'b0;
    end
  end

  assign out_valid = r_main.valid;
  assign out_data  = r_main.data;
  assign occupancy = occ_count(r_main.valid, w_skid_valid);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : directed self-checking bench for pipe_stage_reg
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int          WIDTH   = 32;
  localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(
    .WIDTH  (WIDTH),
    .RST_VAL(RST_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;

    // 1: reset held two cycles with in_valid asserted
    cyc(); cyc();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, RST_VAL);
    check("rst_occ", {30'd0, occupancy}, 32'd0);
    reset = 1'b0; in_valid = 1'b0; #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    check("rst_idle_valid", {31'd0, out_valid}, 32'd0);

    // 2: streaming 1..4 with no bubbles
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      cyc();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_data", out_data, i);
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    check("stream_drain", {31'd0, out_valid}, 32'd0);

    // 3: stall with 0xB waiting upstream
    in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
    cyc();
    check("stall_first", out_data, 32'hA);
    out_ready = 1'b0; in_data = 32'hB; #1;
`ifdef PIPE_SKID_EN
    check("stall_ready0", {31'd0, in_ready}, 32'd1);
`else
    check("stall_ready0", {31'd0, in_ready}, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_data", out_data, 32'hA);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
    end
`ifdef PIPE_SKID_EN
    check("stall_occ", {30'd0, occupancy}, 32'd2);
`else
    check("stall_occ", {30'd0, occupancy}, 32'd1);
`endif
    out_ready = 1'b1;
    cyc();
    check("stall_next", out_data, 32'hB);
    check("stall_next_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cyc();
    check("stall_empty", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_EN
    // 4: 0x5 lands in the skid slot behind stalled 0x4
    in_valid = 1'b1; in_data = 32'h4; out_ready = 1'b1;
    cyc();
    in_data = 32'h5; out_ready = 1'b0;
    cyc();
    check("skid_occ2", {30'd0, occupancy}, 32'd2);
    check("skid_ready", {31'd0, in_ready}, 32'd0);
    check("skid_hold", out_data, 32'h4);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check("skid_second", out_data, 32'h5);
    check("skid_occ1", {30'd0, occupancy}, 32'd1);
    check("skid_ready_back", {31'd0, in_ready}, 32'd1);
    cyc();
    check("skid_occ0", {30'd0, occupancy}, 32'd0);
    check("skid_empty", {31'd0, out_valid}, 32'd0);
`endif

    // 5: flush with a new entry offered in the same cycle
    in_valid = 1'b1; in_data = 32'h6; out_ready = 1'b1;
    cyc();
    in_data = 32'h7; out_ready = 1'b0;
    cyc();
`ifdef PIPE_SKID_EN
    check("pre_flush_occ", {30'd0, occupancy}, 32'd2);
`else
    check("pre_flush_occ", {30'd0, occupancy}, 32'd1);
`endif
    flush = 1'b1; in_data = 32'h9;
    cyc();
    flush = 1'b0; in_valid = 1'b0; #1;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_data_kept", out_data, 32'h6);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    cyc();
    check("flush_no_9", out_data, 32'h6);
    check("flush_still_empty", {31'd0, out_valid}, 32'd0);

    // 6: reset in the middle of a stall
    in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    check("mid_stall_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    cyc();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, RST_VAL);
    check("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    reset = 1'b0; in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b1;
    cyc();
    check("post_rst_data", out_data, 32'h44);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
